fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline; owns the PC and the instruction-memory read handshake.
- Splits each fetched word into the fields the IF/ID register latches: pc, opcode, funct3, funct7, packed register indices and branch-prediction word.
- Handles stall from the hazard unit and redirect from EX; a redirect may arrive while a memory request is outstanding.

Parameters:
- RESET_PC, 32'h4000_0060, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: IF/ID must hold; fetched word is not consumed.
- redirect  in  1  EX: mispredict or jump; squash current fetch.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
- imem_address  out  32  word-aligned fetch address.
- imem_read  out  1  read request; held high until imem_resp.
- imem_rdata  in  32  instruction word; valid when imem_resp=1.
- imem_resp  in  1  one-cycle response strobe.
- load_id  out  1  IF/ID load enable = valid word present & ~stall & ~redirect.
- pc_if  out  32  (rv32i_pc_word) PC of the delivered instruction.
- opcode_if  out  7  (rv32i_opcode) instr[6:0].
- funct3_if  out  3  instr[14:12].
- funct7_if  out  7  instr[31:25].
- regs_if  out  15  (rv32i_reg_word) {rd=instr[11:7], rs2=instr[24:20], rs1=instr[19:15]}.
- brp_if  out  33  (rv32i_brp_word) {pred_taken, pred_target[31:0]}.

Behaviour:
- State machine with states FETCH, DELIVER and DRAIN. Registers:
  - pc: next address to fetch.
  - drain_addr: address of the outstanding request.
  - ibuf: instruction word plus its pc and brp.
- Reset (synchronous):
  - state=FETCH, pc=RESET_PC, ibuf=0.
  - All field outputs are 0 (opcode cast from 0). load_id=0.
  - imem_read is forced 0 while rst=1.
  - Reset mid-request abandons the request; the memory must tolerate read dropping.
- FETCH: imem_read=1, imem_address=pc.
  - imem_resp & ~redirect: ibuf<=imem_rdata and pc; pc<=next_pc; go to DELIVER.
  - imem_resp & redirect: drop the data; pc<=redirect_pc; stay in FETCH.
  - ~imem_resp & redirect: drain_addr<=pc; pc<=redirect_pc; go to DRAIN.
- DRAIN: imem_read=1, imem_address=drain_addr (address stays stable until resp).
  - imem_resp: discard the data; go to FETCH.
  - A further redirect updates pc only.
- DELIVER: imem_read=0; field outputs are decoded combinationally from ibuf.
  - redirect has priority: pc<=redirect_pc; go to FETCH; load_id=0.
  - Else ~stall: load_id=1 this cycle; go to FETCH.
  - Else (stall): hold; load_id=0.
- Field outputs hold their last ibuf decode outside DELIVER. Only load_id qualifies them.
- Latency: minimum 2 cycles per instruction (resp cycle, then delivery cycle); 1 instruction per 2 cycles with a 1-cycle-resp memory.
- next_pc = pred_taken ? pred_target : pc+4. Arithmetic is 32-bit and wraps modulo 2^32 with no overflow flag.
- Redirect and stall in the same cycle: redirect wins.

Optional Feature:
- Macro: STATIC_BTFN_PRED_EN.
- Defined: for opcode BRANCH (7'b1100011), B-imm = sign-extended {i[31],i[7],i[30:25],i[11:8],1'b0}.
  - pred_taken = imm[31]; pred_target = pc+imm.
  - next_pc follows the prediction.
- Undefined: pred_taken=0 and pred_target=pc+4 always; no immediate adder is instantiated.

Decomposition:
- rv32i_types package holds:
  - rv32i_pc_word (32) and rv32i_reg_word (packed rd/rs2/rs1, 15).
  - rv32i_brp_word (packed taken/target, 33) and rv32i_opcode enum including op_br.
  - Fetch FSM state enum fetch_state_t.
- One sub-module, fetch_decode_fields: purely combinational ibuf -> opcode/funct3/funct7/regs/brp. It contains the BTFN logic under the macro.

Test Plan:
- Reset, memory with 1-cycle resp, no stall:
  - First imem_address is 32'h4000_0060.
  - load_id pulses with pc_if 0x40000060, then 0x40000064, at a 2-cycle cadence.
- Fetch instr 32'h00B50633 (add x12,x10,x11):
  - opcode_if=7'h33, funct3_if=0, funct7_if=0.
  - regs_if={rd=12, rs2=11, rs1=10}.
- Stall held 3 cycles in DELIVER:
  - load_id=0 and outputs stable for 3 cycles; imem_read=0.
  - Delivery occurs on the cycle stall drops.
- Redirect to 0x40000100 while the request to 0x40000068 is outstanding (resp delayed 3 cycles):
  - imem_address stays 0x40000068 until resp; that data is never delivered.
  - Next request is to 0x40000100.
- Redirect and stall together in DELIVER: load_id=0; next request is to redirect_pc. Repeat with imem_resp in the same cycle: data dropped.
- With STATIC_BTFN_PRED_EN, branch at 0x40000080 with imm -8:
  - brp_if={1, 0x40000078}; next imem_address is 0x40000078.
  - Without the macro: brp_if={0, 0x40000084}.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I fetch types.
// Holds the packed words latched by IF/ID (pc, register indices, branch
// prediction), the opcode enum, the fetch FSM state enum and the ibuf record.
package rv32i_types;

  typedef logic [31:0] rv32i_pc_word;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs2;
    logic [4:0] rs1;
  } rv32i_reg_word;

  typedef struct packed {
    logic         taken;
    rv32i_pc_word target;
  } rv32i_brp_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [1:0] {
    FETCH,
    DELIVER,
    DRAIN
  } fetch_state_t;

  // Fetched instruction held for delivery, kept in decoded form.
  typedef struct packed {
    rv32i_pc_word  pc;
    rv32i_opcode   opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    rv32i_reg_word regs;
    rv32i_brp_word brp;
  } fetch_ibuf_t;

  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_decode_fields.sv
// Combinational field split of one instruction word.
// Optional feature macro: STATIC_BTFN_PRED_EN (backward-taken/forward-not-taken
// static prediction for conditional branches). When undefined no immediate
// adder exists and the prediction is always not-taken to pc+4.
// Ports:
//   instr_i  : 32-bit instruction word
//   pc_i     : pc of that word
//   opcode_o : instr[6:0]
//   funct3_o : instr[14:12]
//   funct7_o : instr[31:25]
//   regs_o   : {rd, rs2, rs1}
//   brp_o    : {pred_taken, pred_target}
module fetch_decode_fields
  import rv32i_types::*;
(
  input  logic [31:0]   instr_i,
  input  rv32i_pc_word  pc_i,
  output rv32i_opcode   opcode_o,
  output logic [2:0]    funct3_o,
  output logic [6:0]    funct7_o,
  output rv32i_reg_word regs_o,
  output rv32i_brp_word brp_o
);

  rv32i_pc_word seq_pc;

  assign seq_pc = pc_i + PC_STEP;

  always_comb begin
    opcode_o = rv32i_opcode'(instr_i[6:0]);
    funct3_o = instr_i[14:12];
    funct7_o = instr_i[31:25];
    regs_o   = '{rd: instr_i[11:7], rs2: instr_i[24:20], rs1: instr_i[19:15]};
  end

`ifdef STATIC_BTFN_PRED_EN
  logic [31:0] b_imm;
  logic        is_branch;

  always_comb begin
    b_imm        = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    is_branch    = (opcode_o == op_br);
    // Negative offset means a backward branch (loop), predicted taken.
    brp_o.taken  = is_branch & b_imm[31];
    brp_o.target = is_branch ? (pc_i + b_imm) : seq_pc;
  end
`else
  assign brp_o = '{taken: 1'b0, target: seq_pc};
`endif

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC and the
// instruction-memory read handshake, and presents the fields of the
// fetched word to the IF/ID register.
// Optional feature macro: STATIC_BTFN_PRED_EN (see fetch_decode_fields).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   stall          : hazard unit hold of IF/ID
//   redirect       : EX squash, new target on redirect_pc ([1:0] ignored)
//   imem_address   : word-aligned fetch address
//   imem_read      : read request, held until imem_resp
//   imem_rdata     : instruction word, valid with imem_resp
//   imem_resp      : one-cycle response strobe
//   load_id        : IF/ID load enable
//   pc_if .. brp_if: fields of the buffered instruction
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   imem_address,
  output logic          imem_read,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_resp,
  output logic          load_id,
  output rv32i_pc_word  pc_if,
  output rv32i_opcode   opcode_if,
  output logic [2:0]    funct3_if,
  output logic [6:0]    funct7_if,
  output rv32i_reg_word regs_if,
  output rv32i_brp_word brp_if
);

  fetch_state_t  state_q, state_d;
  rv32i_pc_word  pc_q, pc_d;
  rv32i_pc_word  drain_addr_q, drain_addr_d;
  fetch_ibuf_t   ibuf_q, ibuf_d;

  rv32i_pc_word  redirect_target;
  rv32i_pc_word  next_pc;

  rv32i_opcode   dec_opcode;
  logic [2:0]    dec_funct3;
  logic [6:0]    dec_funct7;
  rv32i_reg_word dec_regs;
  rv32i_brp_word dec_brp;

  // The word is split as it arrives: the prediction is needed in the
  // response cycle to pick next_pc, so the decoded record is what ibuf holds.
  fetch_decode_fields u_decode (
    .instr_i  (imem_rdata),
    .pc_i     (pc_q),
    .opcode_o (dec_opcode),
    .funct3_o (dec_funct3),
    .funct7_o (dec_funct7),
    .regs_o   (dec_regs),
    .brp_o    (dec_brp)
  );

  assign redirect_target = redirect_pc & ADDR_ALIGN_MASK;
  assign next_pc         = dec_brp.taken ? dec_brp.target : (pc_q + PC_STEP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (imem_resp && !redirect) begin
          state_d = DELIVER;
        end else if (!imem_resp && redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_resp) begin
          state_d = FETCH;
        end
      end
      DELIVER: begin
        if (redirect || !stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    imem_read    = 1'b0;
    imem_address = pc_q;
    load_id      = 1'b0;
    case (state_q)
      FETCH: begin
        imem_read = 1'b1;
      end
      DRAIN: begin
        imem_read    = 1'b1;
        imem_address = drain_addr_q;
      end
      DELIVER: begin
        load_id = !stall && !redirect;
      end
      default: ;
    endcase
    if (rst) begin
      imem_read = 1'b0;
      load_id   = 1'b0;
    end
  end

  // Datapath next-state
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ibuf_d       = ibuf_q;
    case (state_q)
      FETCH: begin
        if (imem_resp) begin
          if (redirect) begin
            pc_d = redirect_target;
          end else begin
            ibuf_d = '{pc: pc_q, opcode: dec_opcode, funct3: dec_funct3,
                       funct7: dec_funct7, regs: dec_regs, brp: dec_brp};
            pc_d   = next_pc;
          end
        end else if (redirect) begin
          drain_addr_d = pc_q;
          pc_d         = redirect_target;
        end
      end
      DRAIN, DELIVER: begin
        if (redirect) begin
          pc_d = redirect_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      ibuf_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ibuf_q       <= ibuf_d;
    end
  end

  assign pc_if     = ibuf_q.pc;
  assign opcode_if = ibuf_q.opcode;
  assign funct3_if = ibuf_q.funct3;
  assign funct7_if = ibuf_q.funct7;
  assign regs_if   = ibuf_q.regs;
  assign brp_if    = ibuf_q.brp;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps followed by a randomized stall/redirect
// phase, checked against a stream model of delivered instructions.
module tb_fetch_stage;
  import rv32i_types::*;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_address;
  logic          imem_read;
  logic [31:0]   imem_rdata;
  logic          imem_resp;
  logic          load_id;
  rv32i_pc_word  pc_if;
  rv32i_opcode   opcode_if;
  logic [2:0]    funct3_if;
  logic [6:0]    funct7_if;
  rv32i_reg_word regs_if;
  rv32i_brp_word brp_if;

  fetch_stage #(.RESET_PC(32'h4000_0060)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .load_id      (load_id),
    .pc_if        (pc_if),
    .opcode_if    (opcode_if),
    .funct3_if    (funct3_if),
    .funct7_if    (funct7_if),
    .regs_if      (regs_if),
    .brp_if       (brp_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mem_tbl [logic [31:0]];
  logic [31:0] salt;
  int unsigned resp_delay = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed words live in mem_tbl; everything else is an R-type word
  // whose upper bits vary with address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return {a[31:7] ^ salt[31:7], 7'h33};
  endfunction

  function automatic logic [32:0] ref_brp(input logic [31:0] pc, input logic [31:0] w);
`ifdef STATIC_BTFN_PRED_EN
    logic [31:0] imm;
    if (w[6:0] == 7'b1100011) begin
      imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      return {imm[31], pc + imm};
    end
`endif
    return {1'b0, pc + 32'd4};
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w);
    logic [32:0] b;
    b = ref_brp(pc, w);
    return b[32] ? b[31:0] : pc + 32'd4;
  endfunction

  // Memory: responds resp_delay cycles into each request; the request
  // address must not move while the request is outstanding.
  int unsigned mcnt = 0;
  logic [31:0] req_addr = '0;
  always @(posedge clk) begin
    #1;
    if (rst || !imem_read) begin
      imem_resp = 1'b0;
      mcnt      = 0;
    end else begin
      if (imem_resp) begin
        imem_resp = 1'b0;
        mcnt      = 0;
      end
      if (mcnt == 0) req_addr = imem_address;
      else chk("addr_stable", {32'd0, imem_address}, {32'd0, req_addr});
      if (mcnt >= resp_delay) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(imem_address);
      end else begin
        mcnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_load(input string tag, input int unsigned max);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < max; i++) begin
      tick();
      if (load_id) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_load_seen"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    chk({tag, "_pc"}, {32'd0, pc_if}, {32'd0, pc});
    chk({tag, "_opcode"}, {57'd0, 7'(opcode_if)}, {57'd0, w[6:0]});
    chk({tag, "_funct3"}, {61'd0, funct3_if}, {61'd0, w[14:12]});
    chk({tag, "_funct7"}, {57'd0, funct7_if}, {57'd0, w[31:25]});
    chk({tag, "_regs"}, {49'd0, 15'(regs_if)}, {49'd0, w[11:7], w[24:20], w[19:15]});
    chk({tag, "_brp"}, {31'd0, 33'(brp_if)}, {31'd0, ref_brp(pc, w)});
  endtask

  task automatic chk_zero_fields(input string tag);
    chk({tag, "_pc"}, {32'd0, pc_if}, 64'd0);
    chk({tag, "_opcode"}, {57'd0, 7'(opcode_if)}, 64'd0);
    chk({tag, "_funct3"}, {61'd0, funct3_if}, 64'd0);
    chk({tag, "_funct7"}, {57'd0, funct7_if}, 64'd0);
    chk({tag, "_regs"}, {49'd0, 15'(regs_if)}, 64'd0);
    chk({tag, "_brp"}, {31'd0, 33'(brp_if)}, 64'd0);
  endtask

  initial begin
    int c0;
    int c1;
    int n_del;
    bit seen;
    logic [31:0] exp_pc;
    logic [31:0] rp;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0;
    salt = $urandom;
    mem_tbl[32'h4000_0100] = 32'h00B5_0633;   // add x12,x10,x11
    mem_tbl[32'h4000_0080] = 32'hFE00_0CE3;   // beq x0,x0,-8

    // Reset state
    tick(); tick();
    chk("rst_read", {63'd0, imem_read}, 64'd0);
    chk("rst_load", {63'd0, load_id}, 64'd0);
    chk_zero_fields("rst");

    // 1-cycle memory, no stall: 2-cycle delivery cadence
    rst = 1'b0;
    #1;
    chk("first_addr", {32'd0, imem_address}, 64'h4000_0060);
    chk("first_read", {63'd0, imem_read}, 64'd1);
    wait_load("d60", 10);
    c0 = cyc;
    chk_fields("d60", 32'h4000_0060);
    wait_load("d64", 10);
    c1 = cyc;
    chk_fields("d64", 32'h4000_0064);
    chk("cadence", 64'(c1 - c0), 64'd2);

    // Redirect while the request to 0x68 is outstanding
    resp_delay = 3;
    tick();
    chk("req68_addr", {32'd0, imem_address}, 64'h4000_0068);
    chk("req68_resp", {63'd0, imem_resp}, 64'd0);
    redirect = 1'b1; redirect_pc = 32'h4000_0102;
    tick();
    redirect = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_resp) begin
        seen = 1'b1;
        break;
      end
      chk("drain_addr", {32'd0, imem_address}, 64'h4000_0068);
      chk("drain_read", {63'd0, imem_read}, 64'd1);
      chk("drain_load", {63'd0, load_id}, 64'd0);
      tick();
    end
    chk("drain_resp_seen", {63'd0, seen}, 64'd1);
    resp_delay = 0;
    tick();
    chk("after_drain_addr", {32'd0, imem_address}, 64'h4000_0100);
    chk("after_drain_read", {63'd0, imem_read}, 64'd1);

    // Stall held 3 cycles in DELIVER on the add instruction
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_load", {63'd0, load_id}, 64'd0);
      chk("stall_read", {63'd0, imem_read}, 64'd0);
      chk("add_pc", {32'd0, pc_if}, 64'h4000_0100);
      chk("add_opcode", {57'd0, 7'(opcode_if)}, 64'h33);
      chk("add_funct3", {61'd0, funct3_if}, 64'd0);
      chk("add_funct7", {57'd0, funct7_if}, 64'd0);
      chk("add_regs", {49'd0, 15'(regs_if)}, {49'd0, 5'd12, 5'd11, 5'd10});
    end
    tick();
    stall = 1'b0;
    #1;
    chk("unstall_load", {63'd0, load_id}, 64'd1);
    chk("unstall_pc", {32'd0, pc_if}, 64'h4000_0100);

    // Redirect + stall in DELIVER
    tick();
    chk("req104_addr", {32'd0, imem_address}, 64'h4000_0104);
    stall = 1'b1;
    tick();
    chk("d104_pc", {32'd0, pc_if}, 64'h4000_0104);
    redirect = 1'b1; redirect_pc = 32'h4000_0200;
    #1;
    chk("redir_stall_load", {63'd0, load_id}, 64'd0);
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("req200_addr", {32'd0, imem_address}, 64'h4000_0200);
    chk("req200_read", {63'd0, imem_read}, 64'd1);
    chk("req200_resp", {63'd0, imem_resp}, 64'd1);
    // Redirect + stall in the response cycle: word dropped
    redirect = 1'b1; redirect_pc = 32'h4000_0300; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("req300_addr", {32'd0, imem_address}, 64'h4000_0300);
    chk("req300_read", {63'd0, imem_read}, 64'd1);
    chk("drop200_pc", {32'd0, pc_if}, 64'h4000_0104);
    wait_load("d300", 10);
    chk_fields("d300", 32'h4000_0300);

    // Branch at 0x80 with offset -8
    tick();
    redirect = 1'b1; redirect_pc = 32'h4000_0080;
    tick();
    redirect = 1'b0;
    wait_load("br80", 10);
`ifdef STATIC_BTFN_PRED_EN
    chk("br80_brp", {31'd0, 33'(brp_if)}, {31'd0, 1'b1, 32'h4000_0078});
`else
    chk("br80_brp", {31'd0, 33'(brp_if)}, {31'd0, 1'b0, 32'h4000_0084});
`endif
    tick();
`ifdef STATIC_BTFN_PRED_EN
    chk("br80_next", {32'd0, imem_address}, 64'h4000_0078);
`else
    chk("br80_next", {32'd0, imem_address}, 64'h4000_0084);
`endif

    // PC wraps modulo 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    wait_load("wrap", 10);
    chk_fields("wrap", 32'hFFFF_FFFC);
    tick();
    chk("wrap_next", {32'd0, imem_address}, 64'h0);

    // Randomized stall / redirect / memory latency against the stream model
    exp_pc = 32'h4000_0040;
    redirect = 1'b1; redirect_pc = exp_pc;
    tick();
    n_del = 0;
    for (int i = 0; i < 300; i++) begin
      stall      = ($urandom_range(3) == 0);
      redirect   = ($urandom_range(9) == 0);
      rp         = 32'h4000_0000 | ($urandom & 32'h0000_01FF);
      redirect_pc = rp;
      resp_delay = $urandom_range(2);
      #1;
      if (stall || redirect) chk("rnd_blocked", {63'd0, load_id}, 64'd0);
      if (load_id) begin
        chk_fields("rnd", exp_pc);
        exp_pc = ref_next(exp_pc, mem_word(exp_pc));
        n_del++;
      end
      if (redirect) exp_pc = rp & 32'hFFFF_FFFC;
      tick();
    end
    stall = 1'b0; redirect = 1'b0; resp_delay = 0;
    chk("rnd_progress", {63'd0, (n_del >= 20)}, 64'd1);

    // Reset in the middle of an outstanding request
    resp_delay = 3;
    tick();
    rst = 1'b1;
    #1;
    chk("rst2_read", {63'd0, imem_read}, 64'd0);
    chk("rst2_load", {63'd0, load_id}, 64'd0);
    tick();
    chk_zero_fields("rst2");
    rst = 1'b0;
    resp_delay = 0;
    #1;
    chk("rst2_addr", {32'd0, imem_address}, 64'h4000_0060);
    wait_load("rst2_d60", 10);
    chk_fields("rst2_d60", 32'h4000_0060);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
